sc_result_collector: RTL and testbench
======================================

Name: sc_result_collector

Overview:
Downstream stage of sc_dot_product. It consumes the single-bit stochastic result stream and its valid qualifier. It counts ones over fixed frames of 2^WIDTH valid bits and rescales the count to the binary dot-product magnitude. Each frame result is presented on a valid/ready output port, with overrun detection when the consumer stalls.

Parameters:
WIDTH, 8, log2 of frame length; a frame is 2^WIDTH valid bits.
SCALE_SHIFT, 5, left shift applied to the ones count (log2 of DIMENSION plus log2 of WIDTH; 4*8=32).
OUT_WIDTH, WIDTH+1+SCALE_SHIFT, derived output width; not overridden.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-low: rst==0 at a rising clk edge resets the block.
in  in  1  stochastic result bit from sc_dot_product.
in_valid  in  1  qualifies in; bits with in_valid==0 are ignored.
restart  in  1  discard the partial frame and begin a fresh one.
out  out  OUT_WIDTH  scaled frame result: ones_count << SCALE_SHIFT.
out_valid  out  1  out holds an unconsumed result.
out_ready  in  1  consumer accepts out when out_valid && out_ready.
overrun  out  1  sticky: a completed frame was dropped because of back-pressure.

Behaviour:
- Reset (rst==0 at clk edge): out=0, out_valid=0, overrun=0, ones=0, bit_cnt=0, state=IDLE. Reset has priority over all other inputs, including mid-frame.
- Internal registers:
  - ones, WIDTH+1 bits, so 2^WIDTH is representable.
  - bit_cnt, WIDTH bits.
  - state in {IDLE, ACCUM}.
- IDLE:
  - in_valid=1 → ones=in, bit_cnt=1, go to ACCUM.
  - Otherwise stay in IDLE.
- ACCUM, on each in_valid=1 cycle:
  - ones += in and bit_cnt += 1.
  - If bit_cnt == 2^WIDTH-1, the frame completes: final = ones + in, ones=0, bit_cnt=0, go to IDLE.
- ACCUM, with in_valid=0: hold all counters. Gaps in valid never end a frame.
- Frame completion latency: out and out_valid update on the same edge that samples the last bit, so they are visible the following cycle.
- Output register, on completion:
  - If !out_valid, or out_valid && out_ready in the same cycle: out = final << SCALE_SHIFT, out_valid=1.
  - If out_valid && !out_ready: the new result is dropped, out is unchanged, overrun=1.
- Without a completion, out_valid && out_ready → out_valid=0. out keeps its last value.
- overrun clears only on reset.
- restart=1 (checked after reset): ones=0, bit_cnt=0, state=IDLE.
  - The current in bit is discarded, even if in_valid=1.
  - The output register, out_valid and overrun are unaffected.
  - restart coinciding with a would-be completion: restart wins and no result is produced.
- Arithmetic is unsigned with no saturation. Range: 0..2^WIDTH << SCALE_SHIFT, which fits exactly in OUT_WIDTH.
- Accumulation continues while out is held, so the next frame overlaps back-pressure with no lost bits. Only the completed result can be dropped.

Decomposition:
- Shared package sc_pkg:
  - FRAME_LEN(WIDTH) helper.
  - State encodings SC_IDLE=1'b0, SC_ACCUM=1'b1.
  - OUT_WIDTH derivation function, shared with sc_dot_product benches.
- One sub-module, sc_ones_counter:
  - Contains the ones accumulator, bit_cnt and terminal detection.
  - Ports: clk, rst, in, in_valid, restart, done, count.
- The top level holds the FSM and the output/handshake register.

Test Plan:
- 256 valid cycles of in=1, out_ready=1 → out=8192, out_valid high exactly one cycle, asserted the cycle after the 256th bit.
- Alternating 1,0 for 256 valid bits → out=4096. Second identical frame back-to-back → out=4096 again, no gap cycle required.
- 256 valid ones interleaved with 100 cycles of in_valid=0, in=1 → out=8192 (invalid ones ignored), and completion is delayed by 100 cycles.
- out_ready=0; frame A (all ones) then frame B (all zeros) → out stays 8192, overrun=1. Raise out_ready → out_valid falls next cycle, overrun stays 1.
- 100 valid ones, restart pulse, then 256 valid zeros → out=0. No result is emitted at the restart.
- Mid-frame rst=0 for one cycle while out_valid=1 and overrun=1 → next cycle out=0, out_valid=0, overrun=0. The next full frame of ones gives out=8192.

Source files
------------

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and helpers for the stochastic-computing result path
package sc_pkg;

  typedef enum logic {
    SC_IDLE  = 1'b0,
    SC_ACCUM = 1'b1
  } sc_state_e;

  // Number of valid bits in one frame.
  function automatic int frame_len(input int width);
    return 1 << width;
  endfunction

  // Result width: the ones count needs width+1 bits (2^width is reachable),
  // then it is shifted left by scale_shift.
  function automatic int out_width(input int width, input int scale_shift);
    return width + 1 + scale_shift;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - counts ones over a frame of 2^WIDTH valid bits
module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in,
  input  logic           in_valid,
  input  logic           restart,
  output logic           done,
  output logic [WIDTH:0] count
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(frame_len(WIDTH) - 1);

  logic [WIDTH:0]   ones_q;
  logic [WIDTH-1:0] bit_cnt_q;

  // The frame ends on the valid bit that lands on the last index; restart
  // suppresses completion so a discarded frame never produces a result.
  assign done  = in_valid && !restart && (bit_cnt_q == LAST_IDX);
  assign count = ones_q + {{WIDTH{1'b0}}, in};

  // Accumulate valid bits; clear on reset, restart or frame completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_q    <= '0;
      bit_cnt_q <= '0;
    end else if (restart) begin
      ones_q    <= '0;
      bit_cnt_q <= '0;
    end else if (in_valid) begin
      if (bit_cnt_q == LAST_IDX) begin
        ones_q    <= '0;
        bit_cnt_q <= '0;
      end else begin
        ones_q    <= count;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_result_collector.sv
// rtl/sc_result_collector.sv - frames the stochastic bit stream into scaled results with handshake
module sc_result_collector
  import sc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SCALE_SHIFT = 5,
  parameter int OUT_WIDTH   = out_width(WIDTH, SCALE_SHIFT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  input  logic                 in_valid,
  input  logic                 restart,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  sc_state_e              state_q, state_d;
  logic                   cnt_done;
  logic                   frame_done;
  logic [WIDTH:0]         count;
  logic [OUT_WIDTH-1:0]   scaled;

  sc_ones_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .restart  (restart),
    .done     (cnt_done),
    .count    (count)
  );

  // Completion can only happen once a frame has been started.
  assign frame_done = cnt_done && (state_q == SC_ACCUM);
  assign scaled     = OUT_WIDTH'(count) << SCALE_SHIFT;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the first valid bit opens a frame, completion or restart closes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SC_IDLE: begin
        if (in_valid && !restart) begin
          state_d = SC_ACCUM;
        end
      end
      SC_ACCUM: begin
        if (restart || frame_done) begin
          state_d = SC_IDLE;
        end
      end
      default: state_d = SC_IDLE;
    endcase
  end

  // Output holding register: load on completion when free, otherwise drop and flag overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (frame_done) begin
      if (!out_valid || out_ready) begin
        out       <= scaled;
        out_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_result_collector.sv
// tb/tb_sc_result_collector.sv - scoreboard bench for sc_result_collector
module tb_sc_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in;
  logic        in_valid;
  logic        restart;
  logic        out_ready;
  logic [13:0] out;
  logic        out_valid;
  logic        overrun;

  int          vectors = 0;
  int          miscompares = 0;
  logic [13:0] sb_q[$];
  logic [13:0] exp_v;
  int          early;

  sc_result_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .restart   (restart),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic b, input logic v);
    in       = b;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in = 1'b0; in_valid = 1'b0; restart = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out !== 14'd0) begin miscompares++; $display("FAIL reset_out: got %0d want 0", out); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst = 1'b1;
    drive(0, 0);
  endtask

  task automatic test_all_ones;
    out_ready = 1'b1;
    early = 0;
    sb_q.push_back(14'd8192);
    for (int i = 0; i < 256; i++) begin
      drive(1, 1);
      if (i < 255 && out_valid) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL ones_early: got %0d early cycles want 0", early); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ones_valid: got %b want 1", out_valid); end
    vectors++;
    if (sb_q.size() == 0) begin miscompares++; $display("FAIL ones_out: scoreboard empty"); end
    else begin exp_v = sb_q.pop_front(); if (out !== exp_v) begin miscompares++; $display("FAIL ones_out: got %0d want %0d", out, exp_v); end end
    drive(0, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ones_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    early = 0;
    sb_q.push_back(14'd4096);
    sb_q.push_back(14'd4096);
    for (int i = 0; i < 512; i++) begin
      drive((i % 2) == 0, 1);
      if (i == 255 || i == 511) begin
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid%0d: got %b want 1", i, out_valid); end
        vectors++;
        if (sb_q.size() == 0) begin miscompares++; $display("FAIL b2b_out%0d: scoreboard empty", i); end
        else begin exp_v = sb_q.pop_front(); if (out !== exp_v) begin miscompares++; $display("FAIL b2b_out%0d: got %0d want %0d", i, out, exp_v); end end
      end else if (out_valid) begin
        early++;
      end
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL b2b_spurious: got %0d valid cycles want 0", early); end
    drive(0, 0);
  endtask

  task automatic test_gaps;
    out_ready = 1'b1;
    early = 0;
    sb_q.push_back(14'd8192);
    for (int i = 0; i < 256; i++) begin
      drive(1, 1);
      if (i < 255 && out_valid) early++;
      if (i < 100) begin
        drive(1, 0);
        if (out_valid) early++;
      end
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL gaps_early: got %0d early cycles want 0", early); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL gaps_valid: got %b want 1", out_valid); end
    vectors++;
    if (sb_q.size() == 0) begin miscompares++; $display("FAIL gaps_out: scoreboard empty"); end
    else begin exp_v = sb_q.pop_front(); if (out !== exp_v) begin miscompares++; $display("FAIL gaps_out: got %0d want %0d", out, exp_v); end end
    drive(0, 0);
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    sb_q.push_back(14'd8192);
    for (int i = 0; i < 256; i++) drive(1, 1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_a_valid: got %b want 1", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_a_flag: got %b want 0", overrun); end
    for (int i = 0; i < 256; i++) drive(0, 1);
    vectors++; if (out !== 14'd8192) begin miscompares++; $display("FAIL ovr_hold: got %0d want 8192", out); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_b_valid: got %b want 1", out_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_b_flag: got %b want 1", overrun); end
    out_ready = 1'b1;
    vectors++;
    if (sb_q.size() == 0) begin miscompares++; $display("FAIL ovr_out: scoreboard empty"); end
    else begin exp_v = sb_q.pop_front(); if (out !== exp_v) begin miscompares++; $display("FAIL ovr_out: got %0d want %0d", out, exp_v); end end
    drive(0, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drain: got %b want 0", out_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_restart;
    out_ready = 1'b1;
    early = 0;
    for (int i = 0; i < 100; i++) begin drive(1, 1); if (out_valid) early++; end
    restart = 1'b1;
    drive(1, 1);
    restart = 1'b0;
    if (out_valid) early++;
    sb_q.push_back(14'd0);
    for (int i = 0; i < 256; i++) begin
      drive(0, 1);
      if (i < 255 && out_valid) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL restart_early: got %0d early cycles want 0", early); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL restart_valid: got %b want 1", out_valid); end
    vectors++;
    if (sb_q.size() == 0) begin miscompares++; $display("FAIL restart_out: scoreboard empty"); end
    else begin exp_v = sb_q.pop_front(); if (out !== exp_v) begin miscompares++; $display("FAIL restart_out: got %0d want %0d", out, exp_v); end end
    drive(0, 0);
  endtask

  task automatic test_restart_collide;
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) drive(1, 1);
    restart = 1'b1;
    drive(1, 1);
    restart = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL collide_valid: got %b want 0", out_valid); end
    early = 0;
    sb_q.push_back(14'd8192);
    for (int i = 0; i < 256; i++) begin
      drive(1, 1);
      if (i < 255 && out_valid) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL collide_early: got %0d early cycles want 0", early); end
    vectors++;
    if (sb_q.size() == 0) begin miscompares++; $display("FAIL collide_out: scoreboard empty"); end
    else begin exp_v = sb_q.pop_front(); if (out !== exp_v || out_valid !== 1'b1) begin miscompares++; $display("FAIL collide_out: got %0d valid %b want %0d valid 1", out, out_valid, exp_v); end end
    drive(0, 0);
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    sb_q.push_back(14'd8192);
    for (int i = 0; i < 256; i++) drive(1, 1);
    for (int i = 0; i < 256; i++) drive(0, 1);
    for (int i = 0; i < 50; i++) drive(1, 1);
    vectors++; if (out_valid !== 1'b1 || overrun !== 1'b1) begin miscompares++; $display("FAIL mrst_pre: got valid %b overrun %b want 1 1", out_valid, overrun); end
    rst = 1'b0;
    drive(1, 1);
    rst = 1'b1;
    sb_q.delete();
    vectors++; if (out !== 14'd0) begin miscompares++; $display("FAIL mrst_out: got %0d want 0", out); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL mrst_overrun: got %b want 0", overrun); end
    out_ready = 1'b1;
    early = 0;
    sb_q.push_back(14'd8192);
    for (int i = 0; i < 256; i++) begin
      drive(1, 1);
      if (i < 255 && out_valid) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL mrst_early: got %0d early cycles want 0", early); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mrst_valid2: got %b want 1", out_valid); end
    vectors++;
    if (sb_q.size() == 0) begin miscompares++; $display("FAIL mrst_frame: scoreboard empty"); end
    else begin exp_v = sb_q.pop_front(); if (out !== exp_v) begin miscompares++; $display("FAIL mrst_frame: got %0d want %0d", out, exp_v); end end
    drive(0, 0);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_gaps();
    test_overrun();
    test_restart();
    test_restart_collide();
    test_mid_reset();
    vectors++;
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
